// File: rtl/raw_from_32_pkg.sv
// Shared definitions for the 32-bit to 16-bit raw unpacker.
// Holds the stream dtype codes, the packed-10 group geometry (kept identical to
// the packer's) and the unpacker FSM state type.
package raw_from_32_pkg;

  localparam int unsigned DTYPE_WIDTH = 8;

  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_START = 8'h01;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_FRAME_END   = 8'h02;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_START   = 8'h04;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_ROW_END     = 8'h08;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_HEADER      = 8'h10;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL       = 8'h80;
  localparam logic [DTYPE_WIDTH-1:0] DTYPE_PIXEL_MASK  = 8'h80;

  // Packed-10 group: 4 MSB words (4 pixels each) plus one LSB word.
  localparam int unsigned PACK10_GROUP_PIX   = 16;
  localparam int unsigned PACK10_GROUP_WORDS = 5;

  typedef enum logic [1:0] {
    StIdle,
    StSplit,
    StDrain,
    StRowEnd
  } state_e;

  function automatic logic is_pixel(input logic [DTYPE_WIDTH-1:0] dt);
    return (dt & DTYPE_PIXEL_MASK) != '0;
  endfunction

endpackage

// File: rtl/raw10_group_drain.sv
// Packed-10 group store and pixel extractor.
// Holds the four MSB words, the LSB word and the group pixel count n, and
// returns pixel i combinationally as {zeros, msb byte, 2 lsbs}.
// Ports:
//   clk, resetb       clock, async active-low reset
//   i_wr_en/idx/data  store a buffered word (idx 0..3 -> MSB, 4 -> LSB word)
//   i_lsb_from_buf    short group: the LSB word is MSB slot i_lsb_idx
//   i_n_load, i_n     load the pixel count for the coming drain
//   i_idx             pixel index to extract
//   o_n               current pixel count
//   o_pix             extracted 16-bit pixel
module raw10_group_drain #(
  parameter int unsigned PIXEL_WIDTH = 10
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic        i_wr_en,
  input  logic [2:0]  i_wr_idx,
  input  logic [31:0] i_wr_data,
  input  logic        i_lsb_from_buf,
  input  logic [1:0]  i_lsb_idx,
  input  logic        i_n_load,
  input  logic [4:0]  i_n,
  input  logic [3:0]  i_idx,
  output logic [4:0]  o_n,
  output logic [15:0] o_pix
);

  logic [31:0] r_buf [4];
  logic [31:0] r_lsb;
  logic [4:0]  r_n;

  logic [31:0]            w_word;
  logic [PIXEL_WIDTH-3:0] w_msb;
  logic [4:0]             w_shift;
  logic [1:0]             w_lsb;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < 4; i++) r_buf[i] <= '0;
      r_lsb <= '0;
      r_n   <= '0;
    end else begin
      if (i_wr_en) begin
        if (i_wr_idx < 3'd4) r_buf[i_wr_idx[1:0]] <= i_wr_data;
        else                 r_lsb <= i_wr_data;
      end
      if (i_lsb_from_buf) r_lsb <= r_buf[i_lsb_idx];
      if (i_n_load)       r_n   <= i_n;
    end
  end

  always_comb begin
    w_word  = r_buf[i_idx[3:2]];
    // Pixel 0 of a word is its top byte.
    w_msb   = w_word[{~i_idx[1:0], 3'b000} +: (PIXEL_WIDTH - 2)];
    // LSB pairs are packed MSB-first across 2n bits; modulo-32 makes n=16 give 30-2i.
    w_shift = {r_n[3:0], 1'b0} - {i_idx, 1'b0} - 5'd2;
    w_lsb   = r_lsb[w_shift +: 2];
    o_pix   = 16'({w_msb, w_lsb});
  end

  assign o_n = r_n;

endmodule

// File: rtl/raw_from_32.sv
// 32-bit imager stream to 16-bit raw pixel stream unpacker.
// Unpacked mode splits each word into two 16-bit values; packed-10 mode
// buffers MSB words plus an LSB word and drains the group one pixel per cycle.
// Ports:
//   clk, resetb   clock, async active-low reset
//   datai/dvi/dtypei  input word, valid, dtype (accepted when dvi && rdyo)
//   pack          packed-10 select, latched on accepted FRAME_START
//   rdyo          ready to accept a word
//   datao/dvo/dtypeo  registered output value, strobe, dtype
//   dropo         pulse when a partial packed group is discarded
module raw_from_32
  import raw_from_32_pkg::*;
#(
  parameter int unsigned PIXEL_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   resetb,
  input  logic [31:0]            datai,
  input  logic                   dvi,
  input  logic [DTYPE_WIDTH-1:0] dtypei,
  input  logic                   pack,
  output logic                   rdyo,
  output logic [15:0]            datao,
  output logic                   dvo,
  output logic [DTYPE_WIDTH-1:0] dtypeo,
  output logic                   dropo
);

  state_e                 r_state, w_state_d;
  logic [2:0]             r_cnt, w_cnt_d;
  logic [3:0]             r_idx, w_idx_d;
  logic                   r_pack_l, w_pack_d;
  logic                   r_rowend_pend, w_pend_d;
  logic [15:0]            r_hi, w_hi_d;
  logic [DTYPE_WIDTH-1:0] r_hi_dtype, w_hi_dtype_d;
  logic [15:0]            r_datao, w_datao_d;
  logic                   r_dvo, w_dvo_d;
  logic [DTYPE_WIDTH-1:0] r_dtypeo, w_dtypeo_d;
  logic                   r_rdyo, w_rdyo_d;
  logic                   r_dropo, w_drop_d;

  logic       w_accept, w_is_pix, w_is_rowend;
  logic       w_wr_en, w_lsb_from_buf, w_n_load;
  logic [1:0] w_lsb_idx;
  logic [4:0] w_n_val, w_n;
  logic [15:0] w_pix;

  assign w_accept    = dvi && r_rdyo;
  assign w_is_pix    = is_pixel(dtypei);
  assign w_is_rowend = (dtypei == DTYPE_ROW_END);

  raw10_group_drain #(
    .PIXEL_WIDTH(PIXEL_WIDTH)
  ) u_drain (
    .clk           (clk),
    .resetb        (resetb),
    .i_wr_en       (w_wr_en),
    .i_wr_idx      (r_cnt),
    .i_wr_data     (datai),
    .i_lsb_from_buf(w_lsb_from_buf),
    .i_lsb_idx     (w_lsb_idx),
    .i_n_load      (w_n_load),
    .i_n           (w_n_val),
    .i_idx         (r_idx),
    .o_n           (w_n),
    .o_pix         (w_pix)
  );

  always_comb begin
    w_state_d      = r_state;
    w_cnt_d        = r_cnt;
    w_idx_d        = r_idx;
    w_pack_d       = r_pack_l;
    w_pend_d       = r_rowend_pend;
    w_hi_d         = r_hi;
    w_hi_dtype_d   = r_hi_dtype;
    w_datao_d      = r_datao;
    w_dvo_d        = 1'b0;
    w_dtypeo_d     = r_dtypeo;
    w_drop_d       = 1'b0;
    w_wr_en        = 1'b0;
    w_lsb_from_buf = 1'b0;
    w_n_load       = 1'b0;
    w_n_val        = 5'd0;
    w_lsb_idx      = 2'(r_cnt - 3'd1);

    case (r_state)
      StIdle: begin
        if (w_accept) begin
          if (dtypei == DTYPE_FRAME_START) w_pack_d = pack;
          if ((dtypei == DTYPE_HEADER) || (w_is_pix && !r_pack_l)) begin
            w_dvo_d      = 1'b1;
            w_datao_d    = datai[15:0];
            w_dtypeo_d   = dtypei;
            w_hi_d       = datai[31:16];
            w_hi_dtype_d = dtypei;
            w_state_d    = StSplit;
          end else if (w_is_pix) begin
            w_wr_en = 1'b1;
            w_cnt_d = r_cnt + 3'd1;
            if (r_cnt == 3'(PACK10_GROUP_WORDS - 1)) begin
              w_n_load  = 1'b1;
              w_n_val   = 5'(PACK10_GROUP_PIX);
              w_idx_d   = '0;
              w_state_d = StDrain;
            end
          end else if (w_is_rowend && r_pack_l && (r_cnt >= 3'd2)) begin
            // Short group: the last buffered word carries the LSBs.
            w_lsb_from_buf = 1'b1;
            w_n_load       = 1'b1;
            w_n_val        = {r_cnt - 3'd1, 2'b00};
            w_hi_d         = datai[15:0];
            w_pend_d       = 1'b1;
            w_idx_d        = '0;
            w_state_d      = StDrain;
          end else begin
            w_dvo_d    = 1'b1;
            w_datao_d  = datai[15:0];
            w_dtypeo_d = dtypei;
            // A lone buffered word before ROW_END is the dummy LSB word: no drop.
            if (r_pack_l && (r_cnt != 3'd0)) begin
              w_cnt_d  = '0;
              w_drop_d = !w_is_rowend;
            end
          end
        end
      end
      StSplit: begin
        w_dvo_d    = 1'b1;
        w_datao_d  = r_hi;
        w_dtypeo_d = r_hi_dtype;
        w_state_d  = StIdle;
      end
      StDrain: begin
        w_dvo_d    = 1'b1;
        w_datao_d  = w_pix;
        w_dtypeo_d = DTYPE_PIXEL;
        w_idx_d    = r_idx + 4'd1;
        if ({1'b0, r_idx} == (w_n - 5'd1)) begin
          w_cnt_d   = '0;
          w_state_d = r_rowend_pend ? StRowEnd : StIdle;
        end
      end
      StRowEnd: begin
        w_dvo_d    = 1'b1;
        w_datao_d  = r_hi;
        w_dtypeo_d = DTYPE_ROW_END;
        w_pend_d   = 1'b0;
        w_state_d  = StIdle;
      end
      default: w_state_d = StIdle;
    endcase

    w_rdyo_d = (w_state_d == StIdle);
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state       <= StIdle;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_pack_l      <= 1'b0;
      r_rowend_pend <= 1'b0;
      r_hi          <= '0;
      r_hi_dtype    <= '0;
      r_datao       <= '0;
      r_dvo         <= 1'b0;
      r_dtypeo      <= '0;
      r_rdyo        <= 1'b0;
      r_dropo       <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_cnt         <= w_cnt_d;
      r_idx         <= w_idx_d;
      r_pack_l      <= w_pack_d;
      r_rowend_pend <= w_pend_d;
      r_hi          <= w_hi_d;
      r_hi_dtype    <= w_hi_dtype_d;
      r_datao       <= w_datao_d;
      r_dvo         <= w_dvo_d;
      r_dtypeo      <= w_dtypeo_d;
      r_rdyo        <= w_rdyo_d;
      r_dropo       <= w_drop_d;
    end
  end

  assign rdyo   = r_rdyo;
  assign datao  = r_datao;
  assign dvo    = r_dvo;
  assign dtypeo = r_dtypeo;
  assign dropo  = r_dropo;

endmodule

// File: tb/tb_raw_from_32.sv
// Self-checking bench for raw_from_32 against a word-level reference model.
module tb_raw_from_32;
  import raw_from_32_pkg::*;

  typedef struct packed {
    logic [15:0]            d;
    logic [DTYPE_WIDTH-1:0] t;
    logic                   p;
  } out_t;

  logic                   clk;
  logic                   resetb;
  logic [31:0]            datai;
  logic                   dvi;
  logic [DTYPE_WIDTH-1:0] dtypei;
  logic                   pack;
  logic                   rdyo;
  logic [15:0]            datao;
  logic                   dvo;
  logic [DTYPE_WIDTH-1:0] dtypeo;
  logic                   dropo;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int stray_drop = 0;

  out_t        exp_q[$];
  out_t        got_q[$];
  int          got_cyc[$];
  logic        got_rdy[$];
  logic        m_pack;
  logic [31:0] m_wq[$];

  raw_from_32 #(
    .PIXEL_WIDTH(10)
  ) dut (
    .clk   (clk),
    .resetb(resetb),
    .datai (datai),
    .dvi   (dvi),
    .dtypei(dtypei),
    .pack  (pack),
    .rdyo  (rdyo),
    .datao (datao),
    .dvo   (dvo),
    .dtypeo(dtypeo),
    .dropo (dropo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    out_t o;
    o = {datao, dtypeo, dropo};
    if (resetb === 1'b1 && dvo === 1'b1) begin
      got_q.push_back(o);
      got_cyc.push_back(cyc);
      got_rdy.push_back(rdyo);
    end
    if (dropo === 1'b1 && dvo !== 1'b1) stray_drop++;
  end

  // ---------------- reference model ----------------
  task automatic m_emit(input logic [15:0] d, input logic [DTYPE_WIDTH-1:0] t, input logic p);
    out_t o;
    o = {d, t, p};
    exp_q.push_back(o);
  endtask

  // Emit 4*nwords pixels from the buffered MSB words and the given LSB word.
  task automatic m_pixels(input int nwords, input logic [31:0] lsbw);
    int n;
    logic [31:0] msb, lsb;
    n = 4 * nwords;
    for (int k = 0; k < n; k++) begin
      msb = (m_wq[k / 4] >> (24 - 8 * (k % 4))) & 32'hFF;
      lsb = (lsbw >> (2 * n - 2 - 2 * k)) & 32'h3;
      m_emit(16'((msb << 2) | lsb), DTYPE_PIXEL, 1'b0);
    end
  endtask

  task automatic model_word(input logic [DTYPE_WIDTH-1:0] dt, input logic [31:0] d,
                            input logic pk);
    logic pix;
    pix = (dt & DTYPE_PIXEL_MASK) != 0;
    if (dt == DTYPE_HEADER || (pix && !m_pack)) begin
      m_emit(d[15:0], dt, 1'b0);
      m_emit(d[31:16], dt, 1'b0);
    end else if (pix) begin
      m_wq.push_back(d);
      if (m_wq.size() == 5) begin
        m_pixels(4, m_wq[4]);
        m_wq.delete();
      end
    end else if (dt == DTYPE_ROW_END && m_pack && m_wq.size() >= 2) begin
      m_pixels(m_wq.size() - 1, m_wq[m_wq.size() - 1]);
      m_wq.delete();
      m_emit(d[15:0], DTYPE_ROW_END, 1'b0);
    end else if (dt == DTYPE_ROW_END && m_pack && m_wq.size() == 1) begin
      m_wq.delete();
      m_emit(d[15:0], DTYPE_ROW_END, 1'b0);
    end else begin
      m_emit(d[15:0], dt, m_pack && (m_wq.size() != 0));
      m_wq.delete();
    end
    if (dt == DTYPE_FRAME_START) m_pack = pk;
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic out_t got_at(input int k);
    if (k < got_q.size()) return got_q[k];
    return 'x;
  endfunction

  task automatic clear_q();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
    got_rdy.delete();
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [DTYPE_WIDTH-1:0] dt, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    model_word(dt, d, pack);
    dtypei = dt;
    datai  = d;
    dvi    = 1'b1;
    for (int c = 0; c < 100 && !ok; c++) begin
      if (rdyo === 1'b1) begin
        @(posedge clk);
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    @(negedge clk);
    dvi = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: dtype %h never accepted (rdyo stuck low)", dt);
    end
  endtask

  task automatic wait_idle();
    int quiet;
    quiet = 0;
    for (int c = 0; c < 400 && quiet < 4; c++) begin
      @(negedge clk);
      if (rdyo === 1'b1) quiet++;
      else quiet = 0;
    end
    n_cmp++;
    if (quiet < 4) begin
      n_err++;
      $display("FAIL idle_timeout: rdyo did not return high, got %b want 1", rdyo);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetb = 1'b0;
    dvi    = 1'b0;
    datai  = '0;
    dtypei = '0;
    pack   = 1'b0;
    m_pack = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (datao !== 16'h0) begin n_err++; $display("FAIL rst_datao: got %h want 0000", datao); end
    n_cmp++; if (dvo !== 1'b0) begin n_err++; $display("FAIL rst_dvo: got %b want 0", dvo); end
    n_cmp++; if (dtypeo !== '0) begin n_err++; $display("FAIL rst_dtypeo: got %h want 00", dtypeo); end
    n_cmp++; if (rdyo !== 1'b0) begin n_err++; $display("FAIL rst_rdyo: got %b want 0", rdyo); end
    n_cmp++; if (dropo !== 1'b0) begin n_err++; $display("FAIL rst_dropo: got %b want 0", dropo); end
    resetb = 1'b1;
    @(negedge clk);
    n_cmp++; if (rdyo !== 1'b1) begin n_err++; $display("FAIL rst_rdyo_rise: got %b want 1", rdyo); end
  endtask

  task automatic test_unpacked();
    out_t g;
    logic exp_rdy [4];
    exp_rdy = '{1'b0, 1'b1, 1'b0, 1'b1};
    clear_q();
    send(DTYPE_HEADER, 32'h0002_0001);
    send(DTYPE_PIXEL, 32'hBBBB_AAAA);
    wait_idle();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL unpk_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      g = got_at(k); n_cmp++;
      if (g !== exp_q[k]) begin
        n_err++;
        $display("FAIL unpk_out[%0d]: got d=%h t=%h p=%b want d=%h t=%h p=%b", k, g.d, g.t, g.p,
                 exp_q[k].d, exp_q[k].t, exp_q[k].p);
      end
    end
    n_cmp++;
    if (got_cyc.size() != 4 || got_cyc[3] - got_cyc[0] != 3) begin
      n_err++; $display("FAIL unpk_consecutive: got %0d outputs not on 4 consecutive cycles", got_cyc.size());
    end
    for (int k = 0; k < 4 && k < got_rdy.size(); k++) begin
      n_cmp++;
      if (got_rdy[k] !== exp_rdy[k]) begin
        n_err++; $display("FAIL unpk_rdyo[%0d]: got %b want %b", k, got_rdy[k], exp_rdy[k]);
      end
    end
  endtask

  task automatic test_packed_full();
    out_t g;
    clear_q();
    pack = 1'b1;
    send(DTYPE_FRAME_START, 32'h0000_0000);
    send(DTYPE_PIXEL, 32'h0001_0203);
    send(DTYPE_PIXEL, 32'h0405_0607);
    send(DTYPE_PIXEL, 32'h0809_0A0B);
    send(DTYPE_PIXEL, 32'h0C0D_0E0F);
    send(DTYPE_PIXEL, 32'h1B1B_1B1B);
    wait_idle();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL full_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      g = got_at(k); n_cmp++;
      if (g !== exp_q[k]) begin
        n_err++;
        $display("FAIL full_out[%0d]: got d=%h t=%h p=%b want d=%h t=%h p=%b", k, g.d, g.t, g.p,
                 exp_q[k].d, exp_q[k].t, exp_q[k].p);
      end
    end
    g = got_at(1); n_cmp++;
    if (g.d !== 16'h0000) begin n_err++; $display("FAIL full_pix0: got %h want 0000", g.d); end
    g = got_at(2); n_cmp++;
    if (g.d !== 16'h0005) begin n_err++; $display("FAIL full_pix1: got %h want 0005", g.d); end
    g = got_at(4); n_cmp++;
    if (g.d !== 16'h000F) begin n_err++; $display("FAIL full_pix3: got %h want 000f", g.d); end
    n_cmp++;
    if (got_cyc.size() != 17 || got_cyc[16] - got_cyc[1] != 15) begin
      n_err++; $display("FAIL full_dvo_run: got %0d outputs, want 16 pixels back-to-back", got_cyc.size());
    end
  endtask

  task automatic test_short_row();
    out_t g;
    int lows;
    clear_q();
    send(DTYPE_PIXEL, 32'h1011_1213);
    send(DTYPE_PIXEL, 32'h1415_1617);
    send(DTYPE_PIXEL, 32'h0000_E4E4);
    send(DTYPE_ROW_END, 32'h0000_0000);
    lows = 0;
    while (rdyo !== 1'b1 && lows < 40) begin
      lows++;
      @(negedge clk);
    end
    n_cmp++;
    if (lows != 9) begin n_err++; $display("FAIL short_rdyo_low: got %0d cycles want 9", lows); end
    wait_idle();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL short_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      g = got_at(k); n_cmp++;
      if (g !== exp_q[k]) begin
        n_err++;
        $display("FAIL short_out[%0d]: got d=%h t=%h p=%b want d=%h t=%h p=%b", k, g.d, g.t, g.p,
                 exp_q[k].d, exp_q[k].t, exp_q[k].p);
      end
    end
    g = got_at(0); n_cmp++;
    if (g.d !== 16'h0043) begin n_err++; $display("FAIL short_pix0: got %h want 0043", g.d); end
  endtask

  task automatic test_row16();
    out_t g;
    clear_q();
    repeat (5) send(DTYPE_PIXEL, $urandom);
    send(DTYPE_PIXEL, 32'h0);
    send(DTYPE_ROW_END, 32'h0000_5A5A);
    wait_idle();
    n_cmp++;
    if (got_q.size() != 17) begin
      n_err++; $display("FAIL row16_count: got %0d outputs want 17", got_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      g = got_at(k); n_cmp++;
      if (g !== exp_q[k]) begin
        n_err++;
        $display("FAIL row16_out[%0d]: got d=%h t=%h p=%b want d=%h t=%h p=%b", k, g.d, g.t, g.p,
                 exp_q[k].d, exp_q[k].t, exp_q[k].p);
      end
    end
  endtask

  task automatic test_drop();
    out_t g;
    out_t e;
    clear_q();
    send(DTYPE_PIXEL, $urandom);
    send(DTYPE_PIXEL, $urandom);
    send(DTYPE_FRAME_END, 32'h1234_5678);
    repeat (5) send(DTYPE_PIXEL, $urandom);
    wait_idle();
    e = {16'h5678, DTYPE_FRAME_END, 1'b1};
    g = got_at(0); n_cmp++;
    if (g !== e) begin
      n_err++; $display("FAIL drop_pulse: got d=%h t=%h p=%b want d=5678 t=%h p=1", g.d, g.t, g.p,
                        DTYPE_FRAME_END);
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL drop_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      g = got_at(k); n_cmp++;
      if (g !== exp_q[k]) begin
        n_err++;
        $display("FAIL drop_out[%0d]: got d=%h t=%h p=%b want d=%h t=%h p=%b", k, g.d, g.t, g.p,
                 exp_q[k].d, exp_q[k].t, exp_q[k].p);
      end
    end
  endtask

  task automatic test_random();
    out_t g;
    int ev;
    int m;
    logic [DTYPE_WIDTH-1:0] other [3];
    other = '{DTYPE_ROW_START, DTYPE_ROW_END, DTYPE_FRAME_END};
    clear_q();
    for (int it = 0; it < 40; it++) begin
      ev = $urandom_range(0, 7);
      if (ev == 0) begin
        pack = 1'($urandom_range(0, 1));
        send(DTYPE_FRAME_START, $urandom);
      end else if (!m_pack) begin
        case (ev % 3)
          0:       send(DTYPE_PIXEL, $urandom);
          1:       send(DTYPE_HEADER, $urandom);
          default: send(other[$urandom_range(0, 2)], $urandom);
        endcase
      end else begin
        case (ev)
          1, 2: repeat (5) send(DTYPE_PIXEL, $urandom);
          3, 4: begin
            m = $urandom_range(1, 3);
            repeat (m + 1) send(DTYPE_PIXEL, $urandom);
            send(DTYPE_ROW_END, $urandom);
          end
          5: begin
            repeat (6) send(DTYPE_PIXEL, $urandom);
            send(DTYPE_ROW_END, $urandom);
          end
          6: begin
            m = $urandom_range(1, 4);
            repeat (m) send(DTYPE_PIXEL, $urandom);
            send(($urandom_range(0, 1) != 0) ? DTYPE_FRAME_END : DTYPE_ROW_START, $urandom);
          end
          default: send(DTYPE_HEADER, $urandom);
        endcase
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_idle();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      g = got_at(k); n_cmp++;
      if (g !== exp_q[k]) begin
        n_err++;
        $display("FAIL rand_out[%0d]: got d=%h t=%h p=%b want d=%h t=%h p=%b", k, g.d, g.t, g.p,
                 exp_q[k].d, exp_q[k].t, exp_q[k].p);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    out_t g;
    bit seen;
    clear_q();
    pack = 1'b1;
    send(DTYPE_FRAME_START, 32'h0);
    repeat (5) send(DTYPE_PIXEL, $urandom);
    seen = 1'b0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(posedge clk);
      #1;
      if (got_q.size() >= 6) seen = 1'b1;
    end
    n_cmp++;
    if (!seen) begin n_err++; $display("FAIL mid_wait: got %0d outputs want 6", got_q.size()); end
    resetb = 1'b0;
    #1;
    n_cmp++; if (dvo !== 1'b0) begin n_err++; $display("FAIL mid_dvo: got %b want 0", dvo); end
    n_cmp++; if (rdyo !== 1'b0) begin n_err++; $display("FAIL mid_rdyo: got %b want 0", rdyo); end
    clear_q();
    m_wq.delete();
    m_pack = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    @(negedge clk);
    n_cmp++; if (rdyo !== 1'b1) begin n_err++; $display("FAIL mid_rdyo_rise: got %b want 1", rdyo); end
    n_cmp++;
    if (got_q.size() != 0) begin
      n_err++; $display("FAIL mid_flush: got %0d outputs after reset want 0", got_q.size());
    end
    send(DTYPE_FRAME_START, 32'h0);
    repeat (5) send(DTYPE_PIXEL, $urandom);
    wait_idle();
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL mid_count: got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      g = got_at(k); n_cmp++;
      if (g !== exp_q[k]) begin
        n_err++;
        $display("FAIL mid_out[%0d]: got d=%h t=%h p=%b want d=%h t=%h p=%b", k, g.d, g.t, g.p,
                 exp_q[k].d, exp_q[k].t, exp_q[k].p);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_unpacked();
    test_packed_full();
    test_short_row();
    test_row16();
    test_drop();
    test_random();
    test_reset_mid_drain();
    n_cmp++;
    if (stray_drop != 0) begin
      n_err++; $display("FAIL stray_dropo: got %0d pulses without dvo want 0", stray_drop);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
